// File: rtl/grid_game_engine_if.sv
// Keypad-side bus of the grid game engine.
//   KEY       : 4-bit key code from the keypad controller
//   KEY_VALID : high while a key is held
// master = keypad side (drives), slave = game engine (samples).
interface grid_game_engine_if;
    logic [3:0] KEY;
    logic       KEY_VALID;

    modport master (output KEY, output KEY_VALID);
    modport slave  (input  KEY, input  KEY_VALID);
endinterface

// File: rtl/grid_game_engine.sv
// N x N, WIN_LEN-in-a-row two-player game engine.
// Consumes key presses, moves a one-hot cursor, places marks and runs a
// sequential one-start-cell-per-cycle win/draw scan.
// Ports:
//   CLK, RST_BTN         : clock, synchronous active-high reset
//   key_bus (slave)      : KEY code + KEY_VALID level
//   p1_cells, p2_cells   : occupied cells per player (bit row*N+col)
//   cursor               : one-hot selected cell
//   cur_player           : 0 = player 1 to move, 1 = player 2
//   busy, game_over      : scan in progress / game finished
//   winner               : 00 none, 10 p1, 11 p2, 01 draw
//   score_p1, score_p2   : saturating win counters
module grid_game_engine #(
    parameter int unsigned N       = 3,
    parameter int unsigned WIN_LEN = 3,
    parameter int unsigned SCORE_W = 4,
    parameter int unsigned WRAP    = 0
) (
    input  logic                 CLK,
    input  logic                 RST_BTN,
    grid_game_engine_if.slave    key_bus,
    output logic [N*N-1:0]       p1_cells,
    output logic [N*N-1:0]       p2_cells,
    output logic [N*N-1:0]       cursor,
    output logic                 cur_player,
    output logic                 busy,
    output logic                 game_over,
    output logic [1:0]           winner,
    output logic [SCORE_W-1:0]   score_p1,
    output logic [SCORE_W-1:0]   score_p2
);
    localparam int unsigned CELLS = N * N;
    localparam int unsigned RC_W  = $clog2(N);
    localparam int unsigned IDX_W = $clog2(CELLS);
    localparam logic [RC_W-1:0] MAX_RC = RC_W'(N - 1);
    localparam logic [RC_W-1:0] MID_RC = RC_W'(N / 2);

    localparam logic [3:0] KEY_UP    = 4'h2;
    localparam logic [3:0] KEY_DOWN  = 4'h8;
    localparam logic [3:0] KEY_LEFT  = 4'h4;
    localparam logic [3:0] KEY_RIGHT = 4'h6;
    localparam logic [3:0] KEY_ENTER = 4'h5;
    localparam logic [3:0] KEY_ESC   = 4'hD;

    typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

    state_t              state_q, state_d;
    logic [RC_W-1:0]     row_q, row_d, col_q, col_d;
    logic [RC_W-1:0]     scan_r_q, scan_r_d, scan_c_q, scan_c_d;
    logic                first_q, first_d;
    logic                kv_prev_q;
    logic [CELLS-1:0]    p1_d, p2_d, cursor_d;
    logic                cur_player_d, busy_d, game_over_d;
    logic [1:0]          winner_d;
    logic [SCORE_W-1:0]  score_p1_d, score_p2_d;
    logic                press_c, line_hit_c;
    logic [CELLS-1:0]    occupied_c, mover_cells_c;

    function automatic logic [CELLS-1:0] cell_onehot(input logic [RC_W-1:0] r,
                                                     input logic [RC_W-1:0] c);
        return CELLS'(1) << (int'(r) * int'(N) + int'(c));
    endfunction

    // WIN_LEN marks of v starting at (r0,c0) stepping (dr,dc); off-board runs never match
    function automatic logic line_hit(input logic [CELLS-1:0] v, input int r0, input int c0,
                                      input int dr, input int dc);
        int   r_end;
        int   c_end;
        logic hit;
        r_end = r0 + dr * (int'(WIN_LEN) - 1);
        c_end = c0 + dc * (int'(WIN_LEN) - 1);
        if (r_end < 0 || r_end >= int'(N) || c_end < 0 || c_end >= int'(N)) return 1'b0;
        hit = 1'b1;
        for (int k = 0; k < int'(WIN_LEN); k++)
            hit &= v[IDX_W'((r0 + dr * k) * int'(N) + c0 + dc * k)];
        return hit;
    endfunction

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        scan_r_d     = scan_r_q;
        scan_c_d     = scan_c_q;
        first_d      = first_q;
        p1_d         = p1_cells;
        p2_d         = p2_cells;
        cur_player_d = cur_player;
        winner_d     = winner;
        score_p1_d   = score_p1;
        score_p2_d   = score_p2;

        press_c       = key_bus.KEY_VALID & ~kv_prev_q;
        occupied_c    = p1_cells | p2_cells;
        mover_cells_c = cur_player ? p2_cells : p1_cells;
        line_hit_c    = line_hit(mover_cells_c, int'(scan_r_q), int'(scan_c_q), 0, 1)
                      | line_hit(mover_cells_c, int'(scan_r_q), int'(scan_c_q), 1, 0)
                      | line_hit(mover_cells_c, int'(scan_r_q), int'(scan_c_q), 1, 1)
                      | line_hit(mover_cells_c, int'(scan_r_q), int'(scan_c_q), 1, -1);

        if (press_c && key_bus.KEY == KEY_ESC) begin
            // Abandon the game; the other player opens the next one
            state_d      = PLAY;
            p1_d         = '0;
            p2_d         = '0;
            row_d        = MID_RC;
            col_d        = MID_RC;
            scan_r_d     = '0;
            scan_c_d     = '0;
            winner_d     = 2'b00;
            first_d      = ~first_q;
            cur_player_d = ~first_q;
        end else begin
            unique case (state_q)
                PLAY: begin
                    if (press_c) begin
                        case (key_bus.KEY)
                            KEY_UP:    row_d = (row_q != '0) ? row_q - RC_W'(1)
                                                             : ((WRAP != 0) ? MAX_RC : '0);
                            KEY_DOWN:  row_d = (row_q != MAX_RC) ? row_q + RC_W'(1)
                                                                 : ((WRAP != 0) ? '0 : MAX_RC);
                            KEY_LEFT:  col_d = (col_q != '0) ? col_q - RC_W'(1)
                                                             : ((WRAP != 0) ? MAX_RC : '0);
                            KEY_RIGHT: col_d = (col_q != MAX_RC) ? col_q + RC_W'(1)
                                                                 : ((WRAP != 0) ? '0 : MAX_RC);
                            KEY_ENTER: begin
                                if ((cursor & occupied_c) == '0) begin
                                    if (cur_player) p2_d = p2_cells | cursor;
                                    else            p1_d = p1_cells | cursor;
                                    scan_r_d = '0;
                                    scan_c_d = '0;
                                    state_d  = CHECK;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CHECK: begin
                    if (line_hit_c) begin
                        state_d  = OVER;
                        winner_d = {1'b1, cur_player};
                        if (cur_player) begin
                            if (score_p2 != '1) score_p2_d = score_p2 + SCORE_W'(1);
                        end else begin
                            if (score_p1 != '1) score_p1_d = score_p1 + SCORE_W'(1);
                        end
                    end else if (scan_r_q == MAX_RC && scan_c_q == MAX_RC) begin
                        if (&occupied_c) begin
                            state_d  = OVER;
                            winner_d = 2'b01;
                        end else begin
                            state_d      = PLAY;
                            cur_player_d = ~cur_player;
                        end
                    end else if (scan_c_q == MAX_RC) begin
                        scan_c_d = '0;
                        scan_r_d = scan_r_q + RC_W'(1);
                    end else begin
                        scan_c_d = scan_c_q + RC_W'(1);
                    end
                end
                OVER: ;
                default: state_d = PLAY;
            endcase
        end

        cursor_d    = cell_onehot(row_d, col_d);
        busy_d      = (state_d == CHECK);
        game_over_d = (state_d == OVER);
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST_BTN) begin
            state_q    <= PLAY;
            row_q      <= MID_RC;
            col_q      <= MID_RC;
            scan_r_q   <= '0;
            scan_c_q   <= '0;
            first_q    <= 1'b0;
            kv_prev_q  <= 1'b1;   // a key held through reset must not fire
            p1_cells   <= '0;
            p2_cells   <= '0;
            cursor     <= cell_onehot(MID_RC, MID_RC);
            cur_player <= 1'b0;
            busy       <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
            score_p1   <= '0;
            score_p2   <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            scan_r_q   <= scan_r_d;
            scan_c_q   <= scan_c_d;
            first_q    <= first_d;
            kv_prev_q  <= key_bus.KEY_VALID;
            p1_cells   <= p1_d;
            p2_cells   <= p2_d;
            cursor     <= cursor_d;
            cur_player <= cur_player_d;
            busy       <= busy_d;
            game_over  <= game_over_d;
            winner     <= winner_d;
            score_p1   <= score_p1_d;
            score_p2   <= score_p2_d;
        end
    end
endmodule

// File: tb/tb_grid_game_engine.sv
// Bench for grid_game_engine: two instances (3x3/3-in-row/2-bit scores/clamp and
// 5x5/4-in-row/3-bit scores/wrap) share one key stream. A board-level model
// predicts each press outcome and its completion cycle; a monitor compares.
module tb_grid_game_engine;
    localparam int NA = 3, WA = 3, SA = 2, RA = 0;
    localparam int NB = 5, WB = 4, SB = 3, RB = 1;

    logic CLK;
    logic RST_BTN;
    int   cyc;
    int   checks;
    int   failures;

    grid_game_engine_if kbus();

    logic [NA*NA-1:0] a_p1, a_p2, a_cur;
    logic             a_cp, a_busy, a_go;
    logic [1:0]       a_win;
    logic [SA-1:0]    a_s1, a_s2;
    logic [NB*NB-1:0] b_p1, b_p2, b_cur;
    logic             b_cp, b_busy, b_go;
    logic [1:0]       b_win;
    logic [SB-1:0]    b_s1, b_s2;

    grid_game_engine #(.N(NA), .WIN_LEN(WA), .SCORE_W(SA), .WRAP(RA)) dut_a (
        .CLK(CLK), .RST_BTN(RST_BTN), .key_bus(kbus.slave),
        .p1_cells(a_p1), .p2_cells(a_p2), .cursor(a_cur), .cur_player(a_cp),
        .busy(a_busy), .game_over(a_go), .winner(a_win),
        .score_p1(a_s1), .score_p2(a_s2));

    grid_game_engine #(.N(NB), .WIN_LEN(WB), .SCORE_W(SB), .WRAP(RB)) dut_b (
        .CLK(CLK), .RST_BTN(RST_BTN), .key_bus(kbus.slave),
        .p1_cells(b_p1), .p2_cells(b_p2), .cursor(b_cur), .cur_player(b_cp),
        .busy(b_busy), .game_over(b_go), .winner(b_win),
        .score_p1(b_s1), .score_p2(b_s2));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct packed {
        logic [63:0] p1, p2, cur;
        logic        cp, busy, go;
        logic [1:0]  win;
        logic [7:0]  s1, s2;
    } snap_t;

    typedef struct {
        int    due;
        bit    pre;
        snap_t exp;
    } item_t;

    item_t qa[$];
    item_t qb[$];

    // Model state per instance: board 0 empty / 1 p1 / 2 p2
    int mb[2][64];
    int mr[2], mc[2], mp[2], mfirst[2], mover[2], mwin[2], ms1[2], ms2[2], bu[2];

    function automatic int cn(input int k); return (k == 0) ? NA : NB; endfunction
    function automatic int cw(input int k); return (k == 0) ? WA : WB; endfunction
    function automatic int cs(input int k); return (k == 0) ? SA : SB; endfunction
    function automatic int cr(input int k); return (k == 0) ? RA : RB; endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic snap_t msnap(input int k);
        snap_t s;
        int    n;
        s = '0;
        n = cn(k);
        for (int i = 0; i < n * n; i++) begin
            if (mb[k][i] == 1) s.p1[i] = 1'b1;
            if (mb[k][i] == 2) s.p2[i] = 1'b1;
        end
        s.cur[mr[k] * n + mc[k]] = 1'b1;
        s.cp   = (mp[k] != 0);
        s.busy = 1'b0;
        s.go   = (mover[k] != 0);
        s.win  = 2'(mwin[k]);
        s.s1   = 8'(ms1[k]);
        s.s2   = 8'(ms2[k]);
        return s;
    endfunction

    function automatic snap_t dsnap(input int k);
        snap_t s;
        s = '0;
        if (k == 0) begin
            s.p1 = 64'(a_p1); s.p2 = 64'(a_p2); s.cur = 64'(a_cur);
            s.cp = a_cp; s.busy = a_busy; s.go = a_go; s.win = a_win;
            s.s1 = 8'(a_s1); s.s2 = 8'(a_s2);
        end else begin
            s.p1 = 64'(b_p1); s.p2 = 64'(b_p2); s.cur = 64'(b_cur);
            s.cp = b_cp; s.busy = b_busy; s.go = b_go; s.win = b_win;
            s.s1 = 8'(b_s1); s.s2 = 8'(b_s2);
        end
        return s;
    endfunction

    // First start cell (scan order) holding a full line of the mover, else -1
    function automatic int line_start(input int k);
        int n, w, who;
        n   = cn(k);
        w   = cw(k);
        who = mp[k] + 1;
        for (int i = 0; i < n * n; i++) begin
            for (int d = 0; d < 4; d++) begin
                int dr, dc, hits;
                dr   = (d == 0) ? 0 : 1;
                dc   = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
                hits = 0;
                for (int s = 0; s < w; s++) begin
                    int rr, cc;
                    rr = i / n + dr * s;
                    cc = i % n + dc * s;
                    if (rr >= 0 && rr < n && cc >= 0 && cc < n && mb[k][rr * n + cc] == who)
                        hits++;
                end
                if (hits == w) return i;
            end
        end
        return -1;
    endfunction

    function automatic int step(input int v, input int delta, input int n, input int wrap);
        int t;
        t = v + delta;
        if (t < 0)  return (wrap != 0) ? n - 1 : 0;
        if (t >= n) return (wrap != 0) ? 0 : n - 1;
        return t;
    endfunction

    task automatic model_reset(input int k);
        for (int i = 0; i < 64; i++) mb[k][i] = 0;
        mr[k] = cn(k) / 2; mc[k] = cn(k) / 2;
        mp[k] = 0; mfirst[k] = 0; mover[k] = 0; mwin[k] = 0;
        ms1[k] = 0; ms2[k] = 0; bu[k] = 0;
    endtask

    // Predict one press whose edge is sampled right after drive cycle n0
    task automatic model_press(input int k, input logic [3:0] key, input int n0);
        int    n, lat, hit, filled, smax;
        item_t it;
        n    = cn(k);
        lat  = 1;
        it.pre = 1'b0;
        smax = (1 << cs(k)) - 1;
        if (n0 < bu[k]) return;   // scan running: press is dropped
        if (key == 4'hD) begin
            for (int i = 0; i < 64; i++) mb[k][i] = 0;
            mr[k] = n / 2; mc[k] = n / 2;
            mwin[k] = 0; mover[k] = 0;
            mfirst[k] = 1 - mfirst[k];
            mp[k] = mfirst[k];
        end else if (mover[k] == 0) begin
            case (key)
                4'h2: mr[k] = step(mr[k], -1, n, cr(k));
                4'h8: mr[k] = step(mr[k],  1, n, cr(k));
                4'h4: mc[k] = step(mc[k], -1, n, cr(k));
                4'h6: mc[k] = step(mc[k],  1, n, cr(k));
                4'h5: begin
                    if (mb[k][mr[k] * n + mc[k]] == 0) begin
                        mb[k][mr[k] * n + mc[k]] = mp[k] + 1;
                        it.pre = 1'b1;
                        hit = line_start(k);
                        if (hit >= 0) begin
                            lat = 2 + hit;
                            mover[k] = 1;
                            mwin[k] = (mp[k] != 0) ? 3 : 2;
                            if (mp[k] != 0) ms2[k] = (ms2[k] < smax) ? ms2[k] + 1 : smax;
                            else            ms1[k] = (ms1[k] < smax) ? ms1[k] + 1 : smax;
                        end else begin
                            lat = 1 + n * n;
                            filled = 0;
                            for (int i = 0; i < n * n; i++) if (mb[k][i] != 0) filled++;
                            if (filled == n * n) begin
                                mover[k] = 1;
                                mwin[k] = 1;
                            end else begin
                                mp[k] = 1 - mp[k];
                            end
                        end
                        bu[k] = n0 + lat;
                    end
                end
                default: ;
            endcase
        end
        it.due = n0 + lat;
        it.exp = msnap(k);
        if (k == 0) qa.push_back(it);
        else        qb.push_back(it);
    endtask

    task automatic cmp_snap(input string pf, input snap_t a, input snap_t e);
        chk({pf, "_p1_cells"},   a.p1,        e.p1);
        chk({pf, "_p2_cells"},   a.p2,        e.p2);
        chk({pf, "_cursor"},     a.cur,       e.cur);
        chk({pf, "_cur_player"}, 64'(a.cp),   64'(e.cp));
        chk({pf, "_busy"},       64'(a.busy), 64'(e.busy));
        chk({pf, "_game_over"},  64'(a.go),   64'(e.go));
        chk({pf, "_winner"},     64'(a.win),  64'(e.win));
        chk({pf, "_score_p1"},   64'(a.s1),   64'(e.s1));
        chk({pf, "_score_p2"},   64'(a.s2),   64'(e.s2));
    endtask

    // Monitor: one cycle before a scan finishes it must still be busy; on the due cycle compare all
    always @(negedge CLK) begin
        snap_t act;
        if (qa.size() > 0) begin
            act = dsnap(0);
            if (qa[0].pre && cyc == qa[0].due - 1)
                chk("A_still_scanning", 64'({act.busy, act.go}), 64'(2'b10));
            if (cyc == qa[0].due) begin
                cmp_snap("A", act, qa[0].exp);
                void'(qa.pop_front());
            end else if (cyc > qa[0].due) begin
                chk("A_item_missed", 64'(cyc), 64'(qa[0].due));
                void'(qa.pop_front());
            end
        end
        if (qb.size() > 0) begin
            act = dsnap(1);
            if (qb[0].pre && cyc == qb[0].due - 1)
                chk("B_still_scanning", 64'({act.busy, act.go}), 64'(2'b10));
            if (cyc == qb[0].due) begin
                cmp_snap("B", act, qb[0].exp);
                void'(qb.pop_front());
            end else if (cyc > qb[0].due) begin
                chk("B_item_missed", 64'(cyc), 64'(qb[0].due));
                void'(qb.pop_front());
            end
        end
    end

    task automatic settle();
        int w;
        w = 0;
        while ((qa.size() > 0 || qb.size() > 0) && w < 300) begin
            @(negedge CLK);
            w++;
        end
        if (qa.size() > 0 || qb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL settle_timeout pending=%0d required=0", qa.size() + qb.size());
            qa.delete();
            qb.delete();
        end
    endtask

    // One press: KEY_VALID low on entry, held for 'hold' cycles, then released
    task automatic press(input logic [3:0] key, input int hold);
        int n0;
        n0 = cyc;
        if (key == 4'hD && (n0 < bu[0] || n0 < bu[1])) key = 4'h6;
        kbus.KEY = key;
        kbus.KEY_VALID = 1'b1;
        model_press(0, key, n0);
        model_press(1, key, n0);
        repeat (hold) @(negedge CLK);
        kbus.KEY_VALID = 1'b0;
        kbus.KEY = 4'(($urandom_range(0, 1) != 0) ? 4'h0 : 4'hF);
        repeat (1 + $urandom_range(0, 1)) @(negedge CLK);
    endtask

    task automatic do_reset();
        item_t it;
        settle();
        kbus.KEY = 4'h6;
        kbus.KEY_VALID = 1'b1;   // held across reset: must not act afterwards
        RST_BTN = 1'b1;
        repeat (3) @(negedge CLK);
        RST_BTN = 1'b0;
        model_reset(0);
        model_reset(1);
        it.pre = 1'b0;
        it.due = cyc + 1;
        it.exp = msnap(0);
        qa.push_back(it);
        it.exp = msnap(1);
        qb.push_back(it);
        repeat (3) @(negedge CLK);
        kbus.KEY_VALID = 1'b0;
        @(negedge CLK);
    endtask

    task automatic goto(input int k, input int tgt);
        int n;
        n = cn(k);
        settle();
        for (int it = 0; it < 24; it++) begin
            if (mr[k] * n + mc[k] == tgt) break;
            if (tgt / n < mr[k])      press(4'h2, 1);
            else if (tgt / n > mr[k]) press(4'h8, 1);
            else if (tgt % n < mc[k]) press(4'h4, 1);
            else                      press(4'h6, 1);
            settle();
        end
    endtask

    task automatic place(input int k, input int tgt);
        goto(k, tgt);
        press(4'h5, 1);
        press(4'h2, 1);   // lands while the scan runs on whichever instance placed
        settle();
    endtask

    task automatic escape();
        settle();
        press(4'hD, 1);
        settle();
    endtask

    task automatic a_row_win();
        place(0, 0); place(0, 3); place(0, 1); place(0, 4); place(0, 2);
    endtask

    function automatic logic [3:0] rand_key();
        int r;
        r = $urandom_range(0, 15);
        if (r < 2)  return 4'h2;
        if (r < 4)  return 4'h8;
        if (r < 6)  return 4'h4;
        if (r < 8)  return 4'h6;
        if (r < 12) return 4'h5;
        if (r == 12) return 4'hD;
        if (r == 13) return 4'h0;
        if (r == 14) return 4'hF;
        return 4'h7;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog_timeout cycle=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        CLK = 1'b0;
        RST_BTN = 1'b1;
        cyc = 0;
        checks = 0;
        failures = 0;
        kbus.KEY = 4'h0;
        kbus.KEY_VALID = 1'b0;
        model_reset(0);
        model_reset(1);
        repeat (2) @(negedge CLK);

        do_reset();
        a_row_win();                          // p1 row 0 on the 3x3 board

        escape();                             // held RIGHT acts once, then clamps / wraps
        press(4'h6, 100);
        press(4'h6, 1); press(4'h6, 1); press(4'h6, 1);
        settle();

        escape();                             // second ENTER on an occupied cell is ignored
        goto(0, 4);
        press(4'h5, 1); settle();
        press(4'h5, 1); settle();

        escape();                             // 3x3 draw
        place(0, 0); place(0, 1); place(0, 2); place(0, 4); place(0, 3);
        place(0, 5); place(0, 7); place(0, 6); place(0, 8);
        escape();

        for (int g = 0; g < 8; g++) begin     // score saturation for both players
            escape();
            a_row_win();
        end

        escape();                             // 5x5 anti-diagonal win 4,8,12,16
        place(1, 4); place(1, 0); place(1, 8); place(1, 1);
        place(1, 12); place(1, 2); place(1, 16);

        for (int i = 0; i < 300; i++) begin
            if (i == 150) do_reset();
            press(rand_key(), $urandom_range(1, 4));
        end
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
